// File: rtl/quad_encoder_multi.sv
// Multi-channel x4 quadrature decoder: synchroniser, glitch filter, wrap-around position counter.
// Define QENC_VELOCITY_EN to add windowed signed velocity measurement per channel.
module quad_encoder_multi #(
  parameter int CHANNELS    = 2,
  parameter int COUNT_W     = 16,
  parameter int ENCODER_MAX = 64000,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int VEL_WINDOW  = 100000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS-1:0]          a,
  input  logic [CHANNELS-1:0]          b,
  input  logic [CHANNELS-1:0]          clear,
  input  logic [CHANNELS-1:0]          err_clr,
  output logic [CHANNELS*COUNT_W-1:0]  count,
  output logic [CHANNELS-1:0]          dir,
  output logic [CHANNELS-1:0]          step,
  output logic [CHANNELS-1:0]          err,
  output logic [CHANNELS*16-1:0]       velocity,
  output logic                         vel_valid
);

  localparam logic [COUNT_W-1:0] CNT_TOP  = COUNT_W'(ENCODER_MAX - 1);
  localparam int                 RUN_W    = $clog2(FILTER_LEN + 1);
  localparam logic [RUN_W-1:0]   RUN_FULL = RUN_W'(FILTER_LEN);

  if (ENCODER_MAX < 2 || longint'(ENCODER_MAX) > (longint'(1) << COUNT_W) ||
      SYNC_STAGES < 2 || FILTER_LEN < 1 || VEL_WINDOW < 1) begin : g_bad_params
    $error("quad_encoder_multi: illegal parameter set");
  end

`ifdef QENC_VELOCITY_EN
  logic [CHANNELS-1:0] fwd, rev;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [1:0]         sync_q [SYNC_STAGES];
    logic [1:0]         sync_ab, last_q, filt_q, ref_q, ref_d, delta;
    logic [RUN_W-1:0]   run_q, run_d;
    logic               filt_vld_q, base_q, base_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               dir_q, dir_d, err_q, err_d, step_q, fwd_c, rev_c;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= 2'b00;
      end else begin
        sync_q[0] <= {a[g], b[g]};
        for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
    end
    assign sync_ab = sync_q[SYNC_STAGES-1];

    // run_d: consecutive cycles sync_ab has shown its current value, saturating at FILTER_LEN
    always_comb begin
      run_d = RUN_W'(1);
      if (sync_ab == last_q) run_d = (run_q == RUN_FULL) ? RUN_FULL : run_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        last_q     <= 2'b00;
        run_q      <= '0;
        filt_q     <= 2'b00;
        filt_vld_q <= 1'b0;
      end else begin
        last_q <= sync_ab;
        run_q  <= run_d;
        if (run_d == RUN_FULL) begin
          filt_q     <= sync_ab;
          filt_vld_q <= 1'b1;
        end
      end
    end

    // Gray code to position 0..3; the modulo-4 difference classifies the transition
    assign delta = {filt_q[1], ^filt_q} - {ref_q[1], ^ref_q};

    always_comb begin
      cnt_d  = cnt_q;
      dir_d  = dir_q;
      err_d  = err_q;
      ref_d  = ref_q;
      base_d = base_q;
      fwd_c  = 1'b0;
      rev_c  = 1'b0;
      if (err_clr[g]) err_d = 1'b0;
      if (clear[g]) begin
        cnt_d  = '0;
        base_d = 1'b0;
      end else if (!base_q) begin
        if (filt_vld_q) begin
          ref_d  = filt_q;
          base_d = 1'b1;
        end
      end else if (filt_q != ref_q) begin
        ref_d = filt_q;
        case (delta)
          2'd1:    fwd_c = 1'b1;
          2'd3:    rev_c = 1'b1;
          default: err_d = 1'b1;
        endcase
      end
      if (fwd_c) begin
        cnt_d = (cnt_q == CNT_TOP) ? '0 : cnt_q + 1'b1;
        dir_d = 1'b1;
      end else if (rev_c) begin
        cnt_d = (cnt_q == '0) ? CNT_TOP : cnt_q - 1'b1;
        dir_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ref_q  <= 2'b00;
        base_q <= 1'b0;
        cnt_q  <= '0;
        dir_q  <= 1'b0;
        err_q  <= 1'b0;
        step_q <= 1'b0;
      end else begin
        ref_q  <= ref_d;
        base_q <= base_d;
        cnt_q  <= cnt_d;
        dir_q  <= dir_d;
        err_q  <= err_d;
        step_q <= fwd_c | rev_c;
      end
    end

    assign count[g*COUNT_W +: COUNT_W] = cnt_q;
    assign dir[g]  = dir_q;
    assign step[g] = step_q;
    assign err[g]  = err_q;
`ifdef QENC_VELOCITY_EN
    assign fwd[g] = fwd_c;
    assign rev[g] = rev_c;
`endif
  end

`ifdef QENC_VELOCITY_EN
  localparam int                 WIN_W    = (VEL_WINDOW > 1) ? $clog2(VEL_WINDOW) : 1;
  localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(VEL_WINDOW - 1);
  localparam logic signed [15:0] ACC_MAX  = 16'sh7fff;
  localparam logic signed [15:0] ACC_MIN  = 16'sh8000;

  logic [WIN_W-1:0] win_q;
  logic             win_end, vel_valid_q;

  assign win_end = (win_q == WIN_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q       <= '0;
      vel_valid_q <= 1'b0;
    end else begin
      win_q       <= win_end ? '0 : win_q + 1'b1;
      vel_valid_q <= win_end;
    end
  end
  assign vel_valid = vel_valid_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_vel
    logic signed [15:0] acc_q, acc_d, vel_q;

    always_comb begin
      acc_d = acc_q;
      if (fwd[g] && acc_q != ACC_MAX)      acc_d = acc_q + 16'sd1;
      else if (rev[g] && acc_q != ACC_MIN) acc_d = acc_q - 16'sd1;
    end

    // a step landing in the last window cycle is still included in the loaded value
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        acc_q <= '0;
        vel_q <= '0;
      end else begin
        if (win_end) vel_q <= acc_d;
        acc_q <= (win_end || clear[g]) ? 16'sd0 : acc_d;
      end
    end
    assign velocity[g*16 +: 16] = vel_q;
  end
`else
  assign velocity  = '0;
  assign vel_valid = 1'b0;
`endif

endmodule

// File: tb/tb_quad_encoder_multi.sv
// Bench for quad_encoder_multi: per-cycle comparison against a behavioural model plus directed literal checks.
module tb_quad_encoder_multi;
  localparam int CH   = 2;
  localparam int CW   = 16;
  localparam int EMAX = 64000;
  localparam int SYNC = 2;
  localparam int FLEN = 3;
  localparam int VW   = 1000;
  localparam int HL   = SYNC + FLEN;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [CH-1:0]     a = '0, b = '0, clear = '0, err_clr = '0;
  logic [CH*CW-1:0]  count;
  logic [CH-1:0]     dir, step, err;
  logic [CH*16-1:0]  velocity;
  logic              vel_valid;

  int checks = 0;
  int errors = 0;
  int nstep0 = 0;
  int cur [CH];

  quad_encoder_multi #(
    .CHANNELS(CH), .COUNT_W(CW), .ENCODER_MAX(EMAX),
    .SYNC_STAGES(SYNC), .FILTER_LEN(FLEN), .VEL_WINDOW(VW)
  ) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .clear(clear), .err_clr(err_clr),
    .count(count), .dir(dir), .step(step), .err(err),
    .velocity(velocity), .vel_valid(vel_valid)
  );

  always #5 clk = ~clk;

  function automatic int gpos(input int ab);
    case (ab)
      0: return 0;
      1: return 1;
      3: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int g2ab(input int p);
    case (p)
      0: return 0;
      1: return 1;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  // Model: raw[c][i] is the AB sample taken i edges ago; -1 marks "not yet observed since reset".
  int raw [CH][HL];
  int m_filt[CH], m_fvld[CH], m_base[CH], m_ref[CH];
  int m_cnt[CH], m_dir[CH], m_step[CH], m_err[CH];
  int m_acc[CH], m_vel[CH];
  int m_win, m_vv;
  int md, meq, na;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CH; c++) begin
        for (int i = 0; i < HL; i++) raw[c][i] = (i < SYNC) ? 0 : -1;
        m_filt[c] = 0; m_fvld[c] = 0; m_base[c] = 0; m_ref[c] = 0;
        m_cnt[c] = 0; m_dir[c] = 0; m_step[c] = 0; m_err[c] = 0;
        m_acc[c] = 0; m_vel[c] = 0;
      end
      m_win = 0;
      m_vv  = 0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        m_step[c] = 0;
        if (err_clr[c]) m_err[c] = 0;
        if (clear[c]) begin
          m_cnt[c]  = 0;
          m_base[c] = 0;
        end else if (m_base[c] == 0) begin
          if (m_fvld[c] != 0) begin
            m_ref[c]  = m_filt[c];
            m_base[c] = 1;
          end
        end else if (m_filt[c] != m_ref[c]) begin
          md = (gpos(m_filt[c]) - gpos(m_ref[c]) + 4) % 4;
          if (md == 1) begin
            m_cnt[c] = (m_cnt[c] + 1) % EMAX; m_dir[c] = 1; m_step[c] = 1;
          end else if (md == 3) begin
            m_cnt[c] = (m_cnt[c] + EMAX - 1) % EMAX; m_dir[c] = 0; m_step[c] = 1;
          end else begin
            m_err[c] = 1;
          end
          m_ref[c] = m_filt[c];
        end
        for (int i = HL - 1; i > 0; i--) raw[c][i] = raw[c][i-1];
        raw[c][0] = int'({a[c], b[c]});
        meq = 1;
        for (int i = SYNC; i < HL; i++) if (raw[c][i] != raw[c][SYNC]) meq = 0;
        if (meq != 0 && raw[c][SYNC] >= 0) begin
          m_filt[c] = raw[c][SYNC];
          m_fvld[c] = 1;
        end
      end
`ifdef QENC_VELOCITY_EN
      m_vv = (m_win == VW - 1) ? 1 : 0;
      for (int c = 0; c < CH; c++) begin
        na = m_acc[c] + ((m_step[c] != 0) ? ((m_dir[c] != 0) ? 1 : -1) : 0);
        if (na > 32767) na = 32767;
        if (na < -32768) na = -32768;
        if (m_vv != 0) m_vel[c] = na;
        m_acc[c] = (m_vv != 0 || clear[c]) ? 0 : na;
      end
      m_win = (m_win + 1) % VW;
`endif
    end
  end

  task automatic chk(input string nm, input int c, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s ch%0d at %0t: got %0d expected %0d", nm, c, $time, act, exp);
    end
  endtask

  task automatic set_ab(input int c, input int ab, input int hold);
    @(posedge clk); #2;
    a[c] = ab[1];
    b[c] = ab[0];
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic fstep(input int c, input int fwd, input int hold);
    cur[c] = g2ab((gpos(cur[c]) + ((fwd != 0) ? 1 : 3)) % 4);
    set_ab(c, cur[c], hold);
  endtask

  task automatic wait_vv(input string nm);
    int seen;
    seen = 0;
    for (int n = 0; n < 1500 && seen == 0; n++) begin
      @(posedge clk); #1;
      if (vel_valid) seen = 1;
    end
    chk(nm, 0, seen, 1);
  endtask

  initial begin
    int s0, lat, c0;
    cur[0] = 0; cur[1] = 0;
    #1 rst = 1'b0;
    #1;
    fork
      forever begin
        @(negedge clk);
        if (rst && step[0]) nstep0++;
        for (int c = 0; c < CH; c++) begin
          chk("count", c, count[c*CW +: CW], m_cnt[c]);
          chk("dir", c, dir[c], m_dir[c]);
          chk("step", c, step[c], m_step[c]);
          chk("err", c, err[c], m_err[c]);
          chk("velocity", c, $signed(velocity[c*16 +: 16]), m_vel[c]);
        end
        chk("vel_valid", 0, vel_valid, m_vv);
      end
    join_none

    repeat (3) @(posedge clk);
    #2;
    chk("rst_count0", 0, count[0 +: CW], 0);
    chk("rst_step", 0, step, 0);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    s0 = nstep0;
    for (int i = 0; i < 16; i++) fstep(0, 1, 10);
    chk("fwd16_count", 0, count[0 +: CW], 16);
    chk("fwd16_model", 0, m_cnt[0], 16);
    chk("fwd16_dir", 0, dir[0], 1);
    chk("fwd16_steps", 0, nstep0 - s0, 16);
    chk("fwd16_err", 0, err[0], 0);
    chk("fwd16_count1", 1, count[CW +: CW], 0);

    for (int i = 0; i < 16; i++) fstep(0, 0, 10);
    chk("rev16_count", 0, count[0 +: CW], 0);
    chk("rev16_dir", 0, dir[0], 0);
    fstep(0, 0, 10);
    chk("wrap_down", 0, count[0 +: CW], 63999);
    chk("wrap_down_model", 0, m_cnt[0], 63999);
    fstep(0, 0, 10);
    chk("at_63998", 0, count[0 +: CW], 63998);
    fstep(0, 1, 10);
    chk("fwd_63999", 0, count[0 +: CW], 63999);
    fstep(0, 1, 10);
    chk("wrap_up", 0, count[0 +: CW], 0);

    cur[0] = 3;
    set_ab(0, 3, 10);
    chk("illegal_count", 0, count[0 +: CW], 0);
    chk("illegal_err", 0, err[0], 1);
    @(posedge clk); #2 err_clr[0] = 1'b1;
    @(posedge clk); #2 err_clr[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("err_clr", 0, err[0], 0);

    fstep(0, 0, 10);
    chk("pre_glitch", 0, count[0 +: CW], 63999);
    s0 = nstep0;
    @(posedge clk); #2 a[0] = 1'b1;
    repeat (2) @(posedge clk);
    #2 a[0] = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("glitch_count", 0, count[0 +: CW], 63999);
    chk("glitch_steps", 0, nstep0 - s0, 0);
    @(posedge clk); #2 a[0] = 1'b1;
    cur[0] = 3;
    lat = -1;
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (step[0]) lat = n;
    end
    chk("latency", 0, lat, 6);
    chk("latency_count", 0, count[0 +: CW], 0);
    repeat (5) @(posedge clk);
    #1;

    fstep(1, 1, 10);
    fstep(1, 1, 10);
    chk("ch1_count2", 1, count[CW +: CW], 2);
    chk("ch1_isolated", 0, count[0 +: CW], 0);
    fstep(1, 1, 3);
    #1 rst = 1'b0;
    #1;
    chk("midrst_count1", 1, count[CW +: CW], 0);
    chk("midrst_dir", 0, dir, 0);
    chk("midrst_step", 0, step, 0);
    a = 2'b11; b = 2'b11;
    cur[0] = 3; cur[1] = 3;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("base11_count0", 0, count[0 +: CW], 0);
    chk("base11_count1", 1, count[CW +: CW], 0);
    chk("base11_err", 0, err, 0);

    fstep(0, 1, 10);
    fstep(0, 1, 10);
    chk("pre_clear", 0, count[0 +: CW], 2);
    @(posedge clk); #2 a[0] = 1'b0; b[0] = 1'b1;
    cur[0] = 1;
    repeat (5) @(posedge clk);
    #2 clear[0] = 1'b1;
    @(posedge clk); #1;
    chk("clear_step", 0, step[0], 0);
    chk("clear_count", 0, count[0 +: CW], 0);
    #1 clear[0] = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("clear_hold", 0, count[0 +: CW], 0);
    fstep(0, 1, 10);
    chk("after_clear", 0, count[0 +: CW], 1);

`ifdef QENC_VELOCITY_EN
    wait_vv("vv_align");
    for (int i = 0; i < 50; i++) fstep(0, 1, 10);
    wait_vv("vv_fwd_seen");
    c0 = int'($signed(velocity[0 +: 16]));
    chk("vel_fwd50", 0, c0, 50);
    chk("vel_fwd50_model", 0, m_vel[0], 50);
    for (int i = 0; i < 20; i++) fstep(0, 0, 10);
    wait_vv("vv_rev_seen");
    c0 = int'($signed(velocity[0 +: 16]));
    chk("vel_rev20", 0, c0, -20);
    chk("vel_ch1", 1, $signed(velocity[16 +: 16]), 0);
`else
    c0 = int'($signed(velocity[0 +: 16]));
    chk("vel_disabled", 0, c0, 0);
`endif

    repeat (5) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_encoder_multi.md
Name: quad_encoder_multi

Overview:
Multi-channel quadrature decoder that succeeds the single-channel encoder counter. Each channel does the following:
- synchronises its raw A/B motor-encoder inputs;
- glitch-filters them;
- performs x4 decode into a wrap-around position counter;
- reports direction, a step strobe and a sticky illegal-transition flag.

The block sits between the FPGA encoder pins and the register bank read by the control software.

Parameters:
CHANNELS, 2, number of independent encoder channels
COUNT_W, 16, width of each position counter
ENCODER_MAX, 64000, counter modulus; legal count range is 0..ENCODER_MAX-1; must satisfy 2 <= ENCODER_MAX <= 2^COUNT_W
SYNC_STAGES, 2, flip-flop synchroniser depth on a and b (>=2)
FILTER_LEN, 3, consecutive identical synchronised samples needed before a new AB value is accepted (>=1)
VEL_WINDOW, 100000, velocity sample window in clk cycles (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (0 = reset)
a  in  CHANNELS  raw encoder A per channel, asynchronous
b  in  CHANNELS  raw encoder B per channel, asynchronous
clear  in  CHANNELS  synchronous per-channel counter clear
err_clr  in  CHANNELS  synchronous per-channel error-flag clear
count  out  CHANNELS*COUNT_W  position counters, channel i at [i*COUNT_W +: COUNT_W]
dir  out  CHANNELS  last accepted step direction, 1 = forward
step  out  CHANNELS  one-cycle pulse on every accepted count change
err  out  CHANNELS  sticky illegal-transition flag
velocity  out  CHANNELS*16  signed steps per window (optional feature)
vel_valid  out  1  one-cycle pulse when velocity updates (optional feature)

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; per-channel filtered AB and baseline-valid flags cleared; synchroniser and filter registers cleared.
- Pipeline, per channel: SYNC_STAGES synchroniser, then filter, then decode register.
- Filter: the filtered AB takes a new value only after the synchroniser output has held that value for FILTER_LEN consecutive cycles.
- Decode latency: a clean input edge, stable thereafter, changes count/step/dir exactly SYNC_STAGES+FILTER_LEN+1 cycles later (6 at defaults).
- Baseline: the first filtered AB after reset (or after clear) is adopted as the baseline with no count change and no err.
- Forward Gray sequence (AB): 00->01->11->10->00. Each forward step does count+1, dir=1, step=1.
- Reverse sequence: 00->10->11->01->00. Each reverse step does count-1, dir=0, step=1.
- No change in filtered AB: count, dir and err are held; step=0.
- Illegal transition (both bits change, e.g. 00->11): no count change, dir held, step=0, err set. The new AB becomes the reference.
- Wrap:
  - forward at ENCODER_MAX-1 gives 0;
  - reverse at 0 gives ENCODER_MAX-1.
  - Arithmetic is modular; the counter never leaves 0..ENCODER_MAX-1.
- clear[i]: next cycle count=0 and the baseline is re-adopted. clear has priority over a simultaneous step; no step pulse is produced in that cycle.
- err_clr[i]: err cleared next cycle. A simultaneous illegal transition wins, so err stays 1.
- Channels are fully independent; simultaneous events on different channels do not interact.
- Reset mid-operation: takes effect immediately regardless of pipeline contents. After release, the baseline rule applies, so no spurious counts occur.

Optional Feature:
Macro QENC_VELOCITY_EN.

Defined:
- A free-running window counter runs from 0 to VEL_WINDOW-1.
- Per channel, a signed 16-bit accumulator adds +1 per forward step and -1 per reverse step, saturating at +32767/-32768.
- At window end: velocity is loaded with the accumulator value (including a step in the final cycle), the accumulator restarts at 0, and vel_valid pulses for one cycle.
- velocity and vel_valid reset to 0; clear[i] zeroes accumulator i.

Not defined:
- velocity and vel_valid are tied to 0 and no window logic is synthesised.
- The port list is unchanged.

Test Plan:
- Reset released with a=b=0, then 4 full forward cycles on channel 0 (16 transitions, each held 10 cycles) -> count0=16, dir0=1, 16 step pulses, err0=0, count1=0.
- From count0=16, 4 full reverse cycles -> count0=0, dir0=0. One more reverse step -> count0=63999.
- Forward steps from count0=63998 -> 63999 then 0. Illegal 00->11 jump -> count held, err0=1; err_clr -> err0=0.
- Glitch: a0 pulses high for 2 cycles with FILTER_LEN=3 -> no step, count unchanged. A clean edge produces step exactly 6 cycles after the input edge.
- Reset released with a=b=1 -> count=0, err=0 (baseline). clear asserted in the same cycle as a forward step -> count=0, step=0. rst pulsed low mid-stream -> all outputs 0 immediately.
- With QENC_VELOCITY_EN and VEL_WINDOW=1000: 50 forward steps inside one window -> velocity=50 with vel_valid. 20 reverse steps in the next window -> velocity=-20.
